conv_encoder_punct: RTL and testbench

- 802.11a convolutional encoder: rate 1/2, K=7, generators g0=133 (octal), g1=171 (octal).
- Puncturing to rate 2/3 or 3/4, selectable per frame.
- Sits directly downstream of the scrambler: consumes one scrambled bit per input handshake and emits the coded/punctured bits serially toward the interleaver.
- Valid/ready handshake on both sides; holds its output under backpressure.

---
 rtl/wifi_tx_pkg.sv | 52 +++++
 rtl/conv_enc_core.sv | 37 +++
 rtl/conv_encoder_punct.sv | 122 ++++++++++++
 tb/tb_conv_encoder_punct.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the 802.11a transmit chain: rate codes, convolutional
// generators, puncture keep masks and the encoder output FSM state type.
package wifi_tx_pkg;

    localparam int SR_LEN = 6;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // Bit 6 taps the current input, bit 0 taps the input delayed by six.
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    // Keep mask layout: {keep_a, keep_b}.
    localparam logic [1:0] KEEP_AB = 2'b11;
    localparam logic [1:0] KEEP_A  = 2'b10;
    localparam logic [1:0] KEEP_B  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2
    } state_t;

    // Which of A/B survive puncturing for a given rate and phase.
    // The reserved rate code behaves as rate 1/2.
    function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] mask;
        mask = KEEP_AB;
        if (rate == RATE_2_3) begin
            if (phase == 2'd1) mask = KEEP_A;
        end else if (rate == RATE_3_4) begin
            if (phase == 2'd1) mask = KEEP_A;
            else if (phase == 2'd2) mask = KEEP_B;
        end
        return mask;
    endfunction

    // Phase after one accepted input; wraps at the puncture period of the rate.
    function automatic logic [1:0] next_phase(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] nxt;
        nxt = 2'd0;
        if (rate == RATE_2_3) begin
            nxt = (phase == 2'd1) ? 2'd0 : 2'd1;
        end else if (rate == RATE_3_4) begin
            nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// K=7 rate-1/2 convolutional encoder core. Owns the shift register and
// produces A/B for the bit currently presented; clear_first makes the bit
// encode as if the register were zero (start of frame).
module conv_enc_core
    import wifi_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic shift,
    input  logic clear_first,
    output logic a_bit,
    output logic b_bit
);

    logic [SR_LEN-1:0] sr;
    logic [SR_LEN-1:0] eff_sr;
    logic [6:0]        taps;

    // Generator taps over {current bit, delayed-by-1 .. delayed-by-6}.
    always_comb begin
        eff_sr = clear_first ? '0 : sr;
        taps   = {bit_in, eff_sr[0], eff_sr[1], eff_sr[2], eff_sr[3], eff_sr[4], eff_sr[5]};
        a_bit  = ^(taps & G0);
        b_bit  = ^(taps & G1);
    end

    // Shift the accepted bit in; a frame start shifts into an emptied register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift) begin
            sr <= {eff_sr[SR_LEN-2:0], bit_in};
        end
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// 802.11a convolutional encoder with per-frame puncturing to 1/2, 2/3, 3/4.
// Takes one scrambled bit, then serialises the kept coded bits before the
// next bit is taken.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready depends only on state; out_bit/out_valid come only from
// registers and hold until transferred, however long out_ready stays low.
module conv_encoder_punct
    import wifi_tx_pkg::*;
#(
    parameter int RATE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [RATE_W-1:0] rate,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t     state;
    state_t     state_next;
    logic [1:0] frame_rate;
    logic [1:0] phase;
    logic       a_q;
    logic       b_q;
    logic [1:0] keep_q;

    logic       accept;
    logic       xfer;
    logic [1:0] eff_rate;
    logic [1:0] eff_phase;
    logic [1:0] new_keep;
    logic       a_bit;
    logic       b_bit;

    conv_enc_core u_core (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .shift       (accept),
        .clear_first (in_sof),
        .a_bit       (a_bit),
        .b_bit       (b_bit)
    );

    // A frame start takes the new rate and restarts the puncture group.
    always_comb begin
        eff_rate  = in_sof ? rate[1:0] : frame_rate;
        eff_phase = in_sof ? 2'd0 : phase;
        new_keep  = keep_mask(eff_rate, eff_phase);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/output decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        accept     = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = new_keep[1] ? ST_SEND_A : ST_SEND_B;
                end
            end
            ST_SEND_A: begin
                out_valid = 1'b1;
                out_bit   = a_q;
                xfer      = out_ready;
                if (out_ready) begin
                    state_next = keep_q[0] ? ST_SEND_B : ST_IDLE;
                end
            end
            ST_SEND_B: begin
                out_valid = 1'b1;
                out_bit   = b_q;
                xfer      = out_ready;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the coded pair, its keep mask and the frame puncture context on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_rate <= RATE_1_2;
            phase      <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            keep_q     <= 2'b00;
        end else if (accept) begin
            frame_rate <= eff_rate;
            phase      <= next_phase(eff_rate, eff_phase);
            a_q        <= a_bit;
            b_q        <= b_bit;
            keep_q     <= new_keep;
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed impulse/backpressure/sof/reset
// scenarios plus randomized frames against a history-based reference encoder.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [1:0] rate = 2'b00;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int compared = 0;
    int mismatched = 0;

    logic exp_q[$];
    logic got_q[$];
    logic rand_bp = 1'b0;

    localparam logic [6:0] TB_G0 = 7'o133;
    localparam logic [6:0] TB_G1 = 7'o171;

    int   hist[7];
    logic [1:0] m_rate = 2'b00;
    int   m_n = 0;

    conv_encoder_punct dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .rate      (rate),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference encoder: hist[d] is the input delayed by d within the frame.
    task automatic model_accept(input logic b, input logic sof, input logic [1:0] r);
        int a;
        int bb;
        int period;
        int ph;
        if (sof) begin
            for (int d = 0; d < 7; d++) hist[d] = 0;
            m_rate = r;
            m_n = 0;
        end
        for (int d = 6; d > 0; d--) hist[d] = hist[d-1];
        hist[0] = b ? 1 : 0;
        a = 0;
        bb = 0;
        for (int d = 0; d < 7; d++) begin
            if (TB_G0[6-d]) a = a ^ hist[d];
            if (TB_G1[6-d]) bb = bb ^ hist[d];
        end
        period = (m_rate == 2'b01) ? 2 : (m_rate == 2'b10) ? 3 : 1;
        ph = m_n % period;
        if (ph != 2) exp_q.push_back(a[0]);
        if (ph != 1) exp_q.push_back(bb[0]);
        m_n++;
    endtask

    // Scoreboard monitor: samples on falling edges, forked from the main block.
    task automatic monitor_loop();
        logic prev_stall = 1'b0;
        logic prev_bit = 1'b0;
        logic e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    compared++;
                    if (out_valid !== 1'b1 || out_bit !== prev_bit) begin
                        mismatched++;
                        $display("FAIL hold_stable: valid=%b bit=%b required valid=1 bit=%b", out_valid, out_bit, prev_bit);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    got_q.push_back(out_bit);
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL extra_bit: got %b with nothing expected", out_bit);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_bit !== e) begin
                            mismatched++;
                            $display("FAIL out_bit: got %b required %b", out_bit, e);
                        end
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
                prev_bit = out_bit;
            end
        end
    endtask

    // Random backpressure, changed just after rising edges like every other input.
    task automatic bp_loop();
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Driver: present one bit, wait (bounded) for in_ready, let it be accepted.
    task automatic send_bit(input logic b, input logic sof, input logic [1:0] r);
        int cnt;
        bit_in = b;
        in_sof = sof;
        rate = r;
        in_valid = 1'b1;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
            model_accept(b, sof, r);
            #1;
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        rate = $urandom_range(0, 3);
    endtask

    // Wait (bounded) until every expected bit is out and the encoder is idle.
    task automatic wait_drain();
        int cnt = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && cnt < 500) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        compared++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL drain: pending=%0d out_valid=%b required 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic check_got(input string name, input int n, input logic [15:0] pattern);
        logic [15:0] p;
        p = pattern;
        compared++;
        if (got_q.size() != n) begin
            mismatched++;
            $display("FAIL %s_count: got %0d bits required %0d", name, got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                compared++;
                if (got_q[i] !== p[n-1-i]) begin
                    mismatched++;
                    $display("FAIL %s_bit%0d: got %b required %b", name, i, got_q[i], p[n-1-i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_out: valid=%b bit=%b required 0 0", out_valid, out_bit);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_impulse(input logic [1:0] r, input int n_in, input string name,
                                input int n_out, input logic [15:0] pattern);
        out_ready = 1'b1;
        got_q.delete();
        send_bit(1'b1, 1'b1, r);
        for (int i = 1; i < n_in; i++) send_bit(1'b0, 1'b0, 2'b11);
        wait_drain();
        check_got(name, n_out, pattern);
    endtask

    task automatic test_backpressure();
        logic first;
        out_ready = 1'b0;
        got_q.delete();
        send_bit(1'b1, 1'b1, 2'b00);
        first = out_bit;
        // Hold the next bit on the input while the pair is stuck.
        bit_in = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid !== 1'b1 || out_bit !== 1'b1 || in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL backpressure: valid=%b bit=%b in_ready=%b required 1 1 0", out_valid, out_bit, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0, 2'b00);
        wait_drain();
        check_got("backpressure", 4, 16'b1101);
        compared++;
        if (first !== 1'b1) begin
            mismatched++;
            $display("FAIL backpressure_first: got %b required 1", first);
        end
    endtask

    task automatic test_mid_sof();
        out_ready = 1'b1;
        got_q.delete();
        send_bit(1'b1, 1'b1, 2'b10);
        send_bit(1'b1, 1'b1, 2'b00);
        send_bit(1'b0, 1'b0, 2'b10);
        send_bit(1'b0, 1'b0, 2'b01);
        wait_drain();
        check_got("mid_sof", 8, 16'b11_11_01_11);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        got_q.delete();
        send_bit(1'b1, 1'b1, 2'b00);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset_valid: got %b required 0", out_valid);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset_ready: got %b required 1", in_ready);
        end
        got_q.delete();
        send_bit(1'b1, 1'b1, 2'b00);
        wait_drain();
        check_got("after_reset", 2, 16'b11);
    endtask

    task automatic test_random();
        rand_bp = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 20);
            send_bit(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)));
            for (int i = 1; i < len; i++) begin
                send_bit(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 2) == 0) wait_drain();
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        for (int d = 0; d < 7; d++) hist[d] = 0;
        fork
            monitor_loop();
            bp_loop();
        join_none
        test_reset();
        test_impulse(2'b00, 7, "impulse_1_2", 14, 16'b11_01_11_11_00_10_11);
        test_impulse(2'b10, 6, "impulse_3_4", 8, 16'b1101_1100);
        test_impulse(2'b01, 6, "impulse_2_3", 9, 16'b1_1011_1001);
        test_impulse(2'b11, 2, "impulse_rsvd", 4, 16'b1101);
        test_backpressure();
        test_mid_sof();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
